// File: rtl/scanner_link_tx.sv
// scanner_link_tx: framed serial command transmitter, 8 clocks per byte, MSB first.
// Optional idle heartbeat (0x06) is compiled in only with SCANNER_TX_HEARTBEAT_EN.
module scanner_link_tx #(
  parameter int HEARTBEAT_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_code,
  input  logic [7:0] cmd_payload,
  output logic       cmd_ready,
  output logic       dataOut,
  output logic [2:0] frameCounter,
  output logic       busy,
  output logic       cmd_err
);

  // state   | meaning
  // IDLE    | current frame is 0x00 filler (also after a dropped illegal code)
  // CMD     | current frame carries a command code or the heartbeat byte
  // PAYLOAD | current frame carries the byte latched with code 7 or 8
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] payload, payload_nxt;
  logic       pending, pending_nxt;
  logic       err_q, err_nxt;
  logic       load_edge;
  logic       code_legal;
  logic       code_has_payload;

  if (HEARTBEAT_FRAMES < 2 || HEARTBEAT_FRAMES > 255) begin : g_param_check
    $error("scanner_link_tx: HEARTBEAT_FRAMES must be within 2..255");
  end

  assign load_edge        = (frameCounter == 3'd7);
  assign code_legal       = (cmd_code >= 4'd1) && (cmd_code <= 4'd8);
  assign code_has_payload = (cmd_code == 4'd7) || (cmd_code == 4'd8);

  // A payload owed to the previous code frame blocks acceptance at this boundary.
  assign cmd_ready = load_edge && !pending;
  assign dataOut   = shreg[7];
  assign busy      = (state != IDLE);
  assign cmd_err   = err_q;

`ifdef SCANNER_TX_HEARTBEAT_EN
  localparam logic [8:0] HB_LIMIT = 9'(HEARTBEAT_FRAMES);

  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic [8:0] idle_done;
  logic       hb_due;

  // Zero frames completed, including the one finishing at this load edge.
  assign idle_done = (state == IDLE) ? ({1'b0, idle_cnt} + 9'd1) : 9'd0;
  assign hb_due    = (idle_done >= HB_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = {shreg[6:0], 1'b0};
    payload_nxt = payload;
    pending_nxt = pending;
    err_nxt     = 1'b0;
`ifdef SCANNER_TX_HEARTBEAT_EN
    idle_cnt_nxt = idle_cnt;
`endif
    if (load_edge) begin
      shreg_nxt = 8'h00;
      state_nxt = IDLE;
      if (pending) begin
        shreg_nxt   = payload;
        state_nxt   = PAYLOAD;
        pending_nxt = 1'b0;
      end else if (cmd_valid) begin
`ifdef SCANNER_TX_HEARTBEAT_EN
        idle_cnt_nxt = '0;
`endif
        if (code_legal) begin
          shreg_nxt = {4'b0000, cmd_code};
          state_nxt = CMD;
          if (code_has_payload) begin
            payload_nxt = cmd_payload;
            pending_nxt = 1'b1;
          end
        end else begin
          err_nxt = 1'b1;
        end
      end
`ifdef SCANNER_TX_HEARTBEAT_EN
      else if (hb_due) begin
        shreg_nxt    = 8'h06;
        state_nxt    = CMD;
        idle_cnt_nxt = '0;
      end else begin
        idle_cnt_nxt = idle_done[7:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= 8'h00;
      payload      <= 8'h00;
      pending      <= 1'b0;
      err_q        <= 1'b0;
      frameCounter <= 3'd0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      payload      <= payload_nxt;
      pending      <= pending_nxt;
      err_q        <= err_nxt;
      frameCounter <= frameCounter + 3'd1;
    end
  end

endmodule
